// File: rtl/tiny_npu_loader.sv
// Job feeder for the TinyNPU datapath: accepts SIZE*SIZE weights and SIZE activations
// on a byte stream, replays them as load strobes, then sequences the mac/out/done pulses.
module tiny_npu_loader #(
    parameter int SIZE     = 4,
    parameter int NBITS    = 8,
    parameter int MAC_WAIT = SIZE + 2,
    parameter int OUT_WAIT = SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NBITS-1:0]        in_data,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [NBITS-1:0]        w_in,
    output logic                    w_load_val,
    output logic [$clog2(SIZE)-1:0] w_load_sel,
    output logic [NBITS-1:0]        x_in,
    output logic                    x_load_val,
    output logic                    mac_val,
    output logic                    out_val,
    output logic                    busy,
    output logic                    done
);

    localparam int SEL_W    = $clog2(SIZE);
    localparam int WIDX_W   = $clog2(SIZE * SIZE);
    localparam int XIDX_W   = $clog2(SIZE);
    localparam int WAIT_MAX = (MAC_WAIT > OUT_WAIT) ? MAC_WAIT : OUT_WAIT;
    localparam int WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [WIDX_W-1:0] W_LAST = WIDX_W'(SIZE * SIZE - 1);
    localparam logic [XIDX_W-1:0] X_LAST = XIDX_W'(SIZE - 1);
    localparam logic [WIDX_W-1:0] W_DIV  = WIDX_W'(SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        MAC,
        WAIT_MAC,
        OUT,
        WAIT_OUT,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [WIDX_W-1:0]   widx_reg, widx_next;
    logic [XIDX_W-1:0]   xidx_reg, xidx_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic                transfer;

    assign in_rdy   = (state_reg == LOAD_W) || (state_reg == LOAD_X);
    assign transfer = in_val && in_rdy && !abort;

    always_comb begin
        state_next = state_reg;
        widx_next  = widx_reg;
        xidx_next  = xidx_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                // The done cycle is already IDLE; holding off start there keeps the
                // earliest next start in the cycle after done.
                if (start && !done) begin
                    state_next = LOAD_W;
                end
            end
            LOAD_W: begin
                if (transfer) begin
                    if (widx_reg == W_LAST) begin
                        widx_next  = '0;
                        state_next = LOAD_X;
                    end else begin
                        widx_next = widx_reg + 1'b1;
                    end
                end
            end
            LOAD_X: begin
                if (transfer) begin
                    if (xidx_reg == X_LAST) begin
                        xidx_next  = '0;
                        state_next = MAC;
                    end else begin
                        xidx_next = xidx_reg + 1'b1;
                    end
                end
            end
            MAC: begin
                if (MAC_WAIT > 0) begin
                    state_next = WAIT_MAC;
                    wait_next  = WAIT_W'(MAC_WAIT - 1);
                end else begin
                    state_next = OUT;
                end
            end
            WAIT_MAC: begin
                if (wait_reg == '0) begin
                    state_next = OUT;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            OUT: begin
                if (OUT_WAIT > 0) begin
                    state_next = WAIT_OUT;
                    wait_next  = WAIT_W'(OUT_WAIT - 1);
                end else begin
                    state_next = DONE;
                end
            end
            WAIT_OUT: begin
                if (wait_reg == '0) begin
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
            widx_next  = '0;
            xidx_next  = '0;
            wait_next  = '0;
        end
    end

    // Pulse outputs lag their state by one cycle; abort kills anything due next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            widx_reg   <= '0;
            xidx_reg   <= '0;
            wait_reg   <= '0;
            w_in       <= '0;
            w_load_val <= 1'b0;
            w_load_sel <= '0;
            x_in       <= '0;
            x_load_val <= 1'b0;
            mac_val    <= 1'b0;
            out_val    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            widx_reg   <= widx_next;
            xidx_reg   <= xidx_next;
            wait_reg   <= wait_next;
            w_load_val <= transfer && (state_reg == LOAD_W);
            x_load_val <= transfer && (state_reg == LOAD_X);
            if (transfer && (state_reg == LOAD_W)) begin
                w_in       <= in_data;
                w_load_sel <= SEL_W'(widx_reg / W_DIV);
            end
            if (transfer && (state_reg == LOAD_X)) begin
                x_in <= in_data;
            end
            mac_val <= (state_reg == MAC) && !abort;
            out_val <= (state_reg == OUT) && !abort;
            done    <= (state_reg == DONE) && !abort;
            busy    <= !abort && ((state_next != IDLE) || (state_reg == DONE));
        end
    end

endmodule

// File: tb/tb_tiny_npu_loader.sv
// Scoreboard bench: two loaders (default waits and zero waits) share one randomized stream;
// the driver logs expected strobes/pulses by cycle, per-instance monitors compare them.
module tb_tiny_npu_loader;

    localparam int SIZE  = 4;
    localparam int NBITS = 8;
    localparam int NW    = SIZE * SIZE;
    localparam int TOTAL = NW + SIZE;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [1:0] sel;
    } item_t;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic [NBITS-1:0] in_data;
    logic in_val;

    logic [1:0] in_rdy_v, w_v, x_v, mac_v, out_v, busy_v, done_v;
    logic [NBITS-1:0] w_in_v [2];
    logic [NBITS-1:0] x_in_v [2];
    logic [1:0]       sel_v  [2];

    item_t wlog[$];
    item_t xlog[$];
    int    jlog[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            chk(name, i, {7'd0, in_rdy_v[i], w_v[i], x_v[i], mac_v[i], out_v[i], busy_v[i], done_v[i],
                          w_in_v[i], x_in_v[i], sel_v[i]}, 32'd0);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int MW = (gi == 0) ? 6 : 0;
            localparam int OW = (gi == 0) ? 4 : 0;

            tiny_npu_loader #(
                .SIZE(SIZE), .NBITS(NBITS), .MAC_WAIT(MW), .OUT_WAIT(OW)
            ) u_dut (
                .clk(clk), .rst(rst), .start(start), .abort(abort),
                .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy_v[gi]),
                .w_in(w_in_v[gi]), .w_load_val(w_v[gi]), .w_load_sel(sel_v[gi]),
                .x_in(x_in_v[gi]), .x_load_val(x_v[gi]),
                .mac_val(mac_v[gi]), .out_val(out_v[gi]),
                .busy(busy_v[gi]), .done(done_v[gi])
            );

            initial begin : mon
                int wp, xp, mp, op, dp;
                bit idle_chk;
                wp = 0; xp = 0; mp = 0; op = 0; dp = 0; idle_chk = 0;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        idle_chk = 0;
                        continue;
                    end
                    // Entries left behind by a reset are skipped.
                    while (wp < wlog.size() && wlog[wp].cyc < cyc) wp++;
                    while (xp < xlog.size() && xlog[xp].cyc < cyc) xp++;
                    while (mp < jlog.size() && jlog[mp] + 2 < cyc) mp++;
                    while (op < jlog.size() && jlog[op] + 3 + MW < cyc) op++;
                    while (dp < jlog.size() && jlog[dp] + 4 + MW + OW < cyc) dp++;

                    if (wp < wlog.size() && wlog[wp].cyc == cyc) begin
                        chk("w_strobe", gi, {21'd0, w_v[gi], w_in_v[gi], sel_v[gi]},
                            {21'd0, 1'b1, wlog[wp].data, wlog[wp].sel});
                        wp++;
                    end else if (w_v[gi]) begin
                        chk("w_unexpected", gi, 32'(w_v[gi]), 32'd0);
                    end

                    if (xp < xlog.size() && xlog[xp].cyc == cyc) begin
                        chk("x_strobe", gi, {23'd0, x_v[gi], x_in_v[gi]}, {23'd0, 1'b1, xlog[xp].data});
                        xp++;
                    end else if (x_v[gi]) begin
                        chk("x_unexpected", gi, 32'(x_v[gi]), 32'd0);
                    end

                    if (mp < jlog.size() && jlog[mp] + 2 == cyc) begin
                        chk("mac_val", gi, 32'(mac_v[gi]), 32'd1);
                        mp++;
                    end else if (mac_v[gi]) begin
                        chk("mac_unexpected", gi, 32'(mac_v[gi]), 32'd0);
                    end

                    if (op < jlog.size() && jlog[op] + 3 + MW == cyc) begin
                        chk("out_val", gi, 32'(out_v[gi]), 32'd1);
                        op++;
                    end else if (out_v[gi]) begin
                        chk("out_unexpected", gi, 32'(out_v[gi]), 32'd0);
                    end

                    if (idle_chk) begin
                        chk("busy_after_done", gi, 32'(busy_v[gi]), 32'd0);
                        idle_chk = 0;
                    end
                    if (dp < jlog.size() && jlog[dp] + 4 + MW + OW == cyc) begin
                        chk("done", gi, {30'd0, done_v[gi], busy_v[gi]}, 32'd3);
                        dp++;
                        idle_chk = 1;
                    end else if (done_v[gi]) begin
                        chk("done_unexpected", gi, 32'(done_v[gi]), 32'd0);
                    end
                end
            end
        end
    endgenerate

    // mode 0: in_val always high, 1: alternating, 2: random bubbles.
    task automatic run_job(input int mode, input int abort_at, input bit poke, input int reset_at);
        int n, t, k;
        bit v;
        item_t it;
        n = 0; t = 0; k = 0;
        for (int i = 0; i < 2; i++) chk("idle_before_start", i, {30'd0, in_rdy_v[i], busy_v[i]}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) chk("busy_rdy_after_start", i, {30'd0, in_rdy_v[i], busy_v[i]}, 32'd3);
        while (n < TOTAL) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (t % 2 == 0);
            else                v = ($urandom_range(0, 2) != 0);
            t++;
            in_val  = v;
            in_data = (mode == 0) ? ((n < NW) ? 8'(8'h10 + n) : 8'(8'hA0 + n - NW)) : 8'($urandom);
            start   = (poke && n == NW + 1);
            if (n == reset_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk_all_zero("async_reset");
                step();
                step();
                rst   = 1'b1;
                in_val = 1'b1;
                start  = 1'b0;
                repeat (4) begin
                    step();
                    for (int i = 0; i < 2; i++) chk("rdy_after_reset", i, {30'd0, in_rdy_v[i], busy_v[i]}, 32'd0);
                end
                in_val = 1'b0;
                return;
            end
            if (n == abort_at) begin
                abort  = 1'b1;
                in_val = 1'b1;
                step();
                abort  = 1'b0;
                in_val = 1'b0;
                start  = 1'b0;
                for (int i = 0; i < 2; i++) chk("rdy_after_abort", i, {30'd0, in_rdy_v[i], busy_v[i]}, 32'd0);
                repeat (16) step();
                return;
            end
            if (v) begin
                for (int i = 0; i < 2; i++) chk("in_rdy_load", i, 32'(in_rdy_v[i]), 32'd1);
                it.cyc  = cyc + 1;
                it.data = in_data;
                it.sel  = (n < NW) ? 2'(n / SIZE) : 2'd0;
                if (n < NW) wlog.push_back(it);
                else        xlog.push_back(it);
                if (n == TOTAL - 1) k = cyc;
                n++;
            end
            step();
        end
        in_val = 1'b0;
        start  = 1'b0;
        jlog.push_back(k);
        if (poke) begin
            while (cyc < k + 3) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        while (cyc < k + 17) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_val = 1'b0; in_data = '0;
        #2 rst = 1'b0;
        #1 chk_all_zero("reset_values");
        step();
        step();
        rst = 1'b1;
        step();
        run_job(0, -1, 1'b0, -1);
        run_job(1, -1, 1'b0, -1);
        run_job(0, -1, 1'b1, -1);
        run_job(0, 7, 1'b0, -1);
        run_job(0, -1, 1'b0, -1);
        repeat (4) run_job(2, -1, 1'b0, -1);
        run_job(2, -1, 1'b0, 5);
        run_job(2, -1, 1'b1, -1);
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiny_npu_loader.md
# tiny_npu_loader

Upstream feeder for the TinyNPU datapath. It accepts one job at a time as a byte stream on a valid/ready input: SIZE×SIZE weights, then SIZE activations. It replays them as the datapath's load strobes (w_in/w_load_val/w_load_sel, x_in/x_load_val). It then issues the mac_val and out_val pulses with programmable spacing and signals job completion.

## Interface
- SIZE, 4: PE count; also the depth of each weight FIFO and of the activation FIFO.
- NBITS, 8: data width.
- MAC_WAIT, SIZE+2: idle cycles between the mac_val pulse and the out_val pulse (≥0).
- OUT_WAIT, SIZE: idle cycles between the out_val pulse and done (≥0).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  begins a job; sampled only in IDLE.
- abort  in  1  synchronous job cancel; has priority over everything except rst.
- in_data  in  NBITS  stream byte.
- in_val  in  1  in_data valid.
- in_rdy  out  1  loader can accept a byte.
- w_in  out  NBITS  weight byte to the datapath.
- w_load_val  out  1  w_in valid (one cycle per weight).
- w_load_sel  out  $clog2(SIZE)  destination PE of w_in.
- x_in  out  NBITS  activation byte to the datapath.
- x_load_val  out  1  x_in valid.
- mac_val  out  1  one-cycle compute pulse.
- out_val  out  1  one-cycle drain pulse.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

## Operation
- States: IDLE, LOAD_W, LOAD_X, MAC, WAIT_MAC, OUT, WAIT_OUT, DONE.
- IDLE + start → LOAD_W. Start in any other state is ignored (no queuing).
- Handshake: a byte transfers in a cycle with in_val && in_rdy. in_rdy = (state==LOAD_W || state==LOAD_X), decoded from the state register only. It never depends on in_val.
- LOAD_W:
  - Counter widx runs 0..SIZE*SIZE-1 and advances per transfer.
  - Weights are PE-major: byte widx goes to PE widx/SIZE (upper bits of widx), so the first SIZE bytes go to PE 0.
  - The transfer of widx = SIZE*SIZE-1 moves to LOAD_X.
- LOAD_X:
  - Counter xidx runs 0..SIZE-1.
  - The transfer of xidx = SIZE-1 moves to MAC.
- MAC: mac_val is asserted; then WAIT_MAC.
- WAIT_MAC: lasts MAC_WAIT cycles; if MAC_WAIT=0 the state is skipped.
- OUT: out_val is asserted.
- WAIT_OUT: lasts OUT_WAIT cycles; skipped if OUT_WAIT=0.
- DONE: done is asserted; then IDLE.
- Wait counter is $clog2(max(MAC_WAIT,OUT_WAIT)+1) bits, reloaded on entry to each wait state. No wrap-around is possible.
- abort in any non-IDLE state → IDLE next cycle:
  - counters cleared;
  - in_rdy low from the next cycle;
  - a strobe already registered for that next cycle is suppressed;
  - no done pulse.
- Reset values:
  - state IDLE, counters 0;
  - in_rdy, w_load_val, x_load_val, mac_val, out_val, busy, done = 0;
  - w_in, x_in, w_load_sel = 0.

## Timing
- All outputs except in_rdy are registered.
- A transfer in cycle k gives w_load_val (or x_load_val) high in cycle k+1, with w_in/x_in = that byte and w_load_sel = widx/SIZE. In any cycle without such a transfer, the strobe is low.
- w_in/x_in/w_load_sel hold their last value when the strobe is low.
- start in IDLE at cycle s:
  - busy high from s+1 through the done cycle inclusive;
  - in_rdy high from s+1.
- Back-to-back transfers sustain one byte per cycle; in_val low inserts bubbles without state change.
- After the last x transfer at cycle k:
  - x_load_val high at k+1;
  - mac_val high at k+2;
  - out_val high at k+3+MAC_WAIT;
  - done high at k+4+MAC_WAIT+OUT_WAIT;
  - IDLE at k+5+MAC_WAIT+OUT_WAIT.
- The earliest next start is sampled in the cycle after done.
- mac_val, out_val and done are each exactly one cycle wide per job.
- rst low at any time: all outputs go to reset values asynchronously; on release the block idles until start.

## Test plan
- **Basic job** (SIZE=4, MAC_WAIT=6, OUT_WAIT=4), in_val held high:
  - weights 0x10..0x1F → 16 w_load_val cycles with w_load_sel 0,0,0,0,1,…,3,3;
  - x bytes 0xA0..0xA3 → 4 x_load_val cycles;
  - mac_val 1 cycle after the last x_load_val, out_val 7 cycles later, done 5 cycles after that;
  - busy spans start+1..done.
- **Backpressure:** in_val toggles 1,0,1,0 → a strobe only in the cycle after each transfer; byte order and sel sequence unchanged; no duplicates.
- **Start while busy:** start pulsed during LOAD_X and WAIT_MAC → ignored; exactly one done.
- **Abort:** abort after the 7th weight transfer → IDLE next cycle, in_rdy low, no further strobes, no done. A following start loads a fresh 16 weights with w_load_sel starting at 0.
- **Zero waits:** MAC_WAIT=0, OUT_WAIT=0 → mac_val, out_val, done on three consecutive cycles.
- **Reset mid-job:** rst low during LOAD_W → all outputs 0 immediately, including between clock edges. After release, in_rdy stays 0 until start.
